// File: rtl/pixel_readout_serializer.sv
// pixel_readout_serializer
//   Buffers row-parallel pixel words in a small FIFO, then emits them as a
//   byte stream with a valid/ready handshake. Frames are tagged with SOF/EOF.
//   Words that arrive while the FIFO is full are dropped and counted, so the
//   sensor side never stalls.
//   Optional build macro: PIXEL_RO_CHECKSUM_EN appends a modulo-256 sum byte
//   to every frame. That byte carries EOF.
module pixel_readout_serializer #(
   parameter int ROWS        = 2,
   parameter int DEPTH       = 4,
   parameter int FRAME_WORDS = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [ROWS*8-1:0]          pix_data,
   input  logic                       pix_valid,
   output logic [7:0]                 out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       out_sof,
   output logic                       out_eof,
   output logic                       overflow,
   output logic [7:0]                 drop_cnt,
   input  logic                       clear_ovf,
   output logic [$clog2(DEPTH):0]     fifo_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int IW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int WW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
   localparam logic [IW-1:0] LAST_BYTE  = IW'(ROWS - 1);
   localparam logic [WW-1:0] LAST_WORD  = WW'(FRAME_WORDS - 1);
   localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

`ifdef PIXEL_RO_CHECKSUM_EN
   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, CKSUM} state_t;
`else
   typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
`endif

   state_t              state, next_state;
   logic [ROWS*8-1:0]   mem [DEPTH];
   logic [AW-1:0]       wr_ptr, rd_ptr;
   logic [LW-1:0]       level;
   logic [ROWS*8-1:0]   shift_reg;
   logic [IW-1:0]       byte_idx;
   logic [WW-1:0]       word_idx;
   logic [7:0]          cksum;
   logic [7:0]          cur_byte;
   logic                empty, full, push, pop, drop, last_byte, last_word;

   assign empty      = (level == '0);
   assign full       = (level == FULL_LEVEL);
   assign pop        = (state == LOAD);
   assign push       = pix_valid && (!full || pop);
   assign drop       = pix_valid && !push;
   assign last_byte  = (byte_idx == LAST_BYTE);
   assign last_word  = (word_idx == LAST_WORD);
   assign fifo_level = level;

   // Select the current byte of the shift register, byte 0 first.
   always_comb begin
      cur_byte = '0;
      for (int i = 0; i < ROWS; i++) begin
         if (byte_idx == IW'(i)) cur_byte = shift_reg[8*i +: 8];
      end
   end

   // FIFO storage write port.
   // NOTE: the storage array has no reset; the pointers and level define which entries are meaningful.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= pix_data;
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= next_state;
   end

   // Next-state and output decode.
   // NOTE: every output gets a default before the case so no path can hold a stale value and infer a latch.
   always_comb begin
      next_state = state;
      out_valid  = 1'b0;
      out_data   = '0;
      out_sof    = 1'b0;
      out_eof    = 1'b0;
      case (state)
         IDLE:  if (!empty) next_state = LOAD;
         LOAD:  next_state = SHIFT;
         SHIFT: begin
            out_valid = 1'b1;
            out_data  = cur_byte;
            out_sof   = (byte_idx == '0) && (word_idx == '0);
`ifdef PIXEL_RO_CHECKSUM_EN
            if (out_ready && last_byte) begin
               if (last_word)   next_state = CKSUM;
               else if (!empty) next_state = LOAD;
               else             next_state = IDLE;
            end
`else
            out_eof = last_byte && last_word;
            if (out_ready && last_byte) next_state = empty ? IDLE : LOAD;
`endif
         end
`ifdef PIXEL_RO_CHECKSUM_EN
         CKSUM: begin
            out_valid = 1'b1;
            out_data  = cksum;
            out_eof   = 1'b1;
            if (out_ready) next_state = empty ? IDLE : LOAD;
         end
`endif
         default: next_state = IDLE;
      endcase
   end

   // FIFO pointers/level, shift register, byte/word counters and checksum.
   // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         shift_reg <= '0;
         byte_idx  <= '0;
         word_idx  <= '0;
         cksum     <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) begin
            shift_reg <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + AW'(1);
            byte_idx  <= '0;
         end
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
         if (state == SHIFT && out_ready) begin
            cksum <= cksum + cur_byte;
            if (last_byte) word_idx <= last_word ? '0 : word_idx + WW'(1);
            else           byte_idx <= byte_idx + IW'(1);
         end
`ifdef PIXEL_RO_CHECKSUM_EN
         if (state == CKSUM && out_ready) cksum <= '0;
`endif
      end
   end

   // Sticky overflow flag and saturating drop counter; a clear in the same
   // cycle as a drop restarts the count at one.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else if (clear_ovf) begin
         overflow <= drop;
         drop_cnt <= drop ? 8'd1 : 8'd0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_pixel_readout_serializer.sv
// tb_pixel_readout_serializer
//   Directed tests for pixel_readout_serializer (ROWS=2, DEPTH=4,
//   FRAME_WORDS=2). With PIXEL_RO_CHECKSUM_EN defined, the checksum frame
//   test replaces the tests whose frames would gain a checksum byte.
module tb_pixel_readout_serializer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] pix_data = '0;
   logic        pix_valid = 1'b0;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        out_sof, out_eof;
   logic        overflow;
   logic [7:0]  drop_cnt;
   logic        clear_ovf = 1'b0;
   logic [2:0]  fifo_level;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] got_data[$];
   logic       got_sof[$];
   logic       got_eof[$];
   int         got_cyc[$];

   pixel_readout_serializer #(.ROWS(2), .DEPTH(4), .FRAME_WORDS(2)) dut (
      .clk(clk), .reset(reset), .pix_data(pix_data), .pix_valid(pix_valid),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_sof(out_sof), .out_eof(out_eof), .overflow(overflow),
      .drop_cnt(drop_cnt), .clear_ovf(clear_ovf), .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [15:0] w);
      pix_data  = w;
      pix_valid = 1'b1;
      tick();
      pix_valid = 1'b0;
   endtask

   task automatic do_reset();
      pix_valid = 1'b0;
      clear_ovf = 1'b0;
      out_ready = 1'b0;
      reset     = 1'b0;
      tick();
      tick();
      @(negedge clk);
      reset = 1'b1;
      tick();
   endtask

   // Record every accepted byte for a fixed number of cycles.
   task automatic collect(input int cycles);
      got_data.delete(); got_sof.delete(); got_eof.delete(); got_cyc.delete();
      for (int c = 0; c < cycles; c++) begin
         if (out_valid && out_ready) begin
            got_data.push_back(out_data);
            got_sof.push_back(out_sof);
            got_eof.push_back(out_eof);
            got_cyc.push_back(c);
         end
         tick();
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #3;
      n_checks++;
      if ({out_valid, out_data, out_sof, out_eof, overflow, drop_cnt, fifo_level} !== 21'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got valid=%b data=%h sof=%b eof=%b ovf=%b drops=%0d level=%0d, want all 0",
                  out_valid, out_data, out_sof, out_eof, overflow, drop_cnt, fifo_level);
      end
      do_reset();
      n_checks++;
      if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_release_idle: got valid=%b level=%0d, want 0 0", out_valid, fifo_level);
      end
   endtask

   task automatic test_single_word();
      do_reset();
      out_ready = 1'b1;
      push_word(16'hB2A1);
      n_checks++;
      if (out_valid !== 1'b0 || fifo_level !== 3'd1) begin
         n_fail++;
         $display("FAIL single_after_push: got valid=%b level=%0d, want 0 1", out_valid, fifo_level);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_load_cycle: got valid=%b, want 0", out_valid);
      end
      tick();
      n_checks++;
      if ({out_valid, out_data, out_sof, out_eof} !== {1'b1, 8'hA1, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL single_byte0: got valid=%b data=%h sof=%b eof=%b, want 1 a1 1 0",
                  out_valid, out_data, out_sof, out_eof);
      end
      tick();
      n_checks++;
      if ({out_valid, out_data, out_sof, out_eof} !== {1'b1, 8'hB2, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL single_byte1: got valid=%b data=%h sof=%b eof=%b, want 1 b2 0 0",
                  out_valid, out_data, out_sof, out_eof);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin
         n_fail++;
         $display("FAIL single_done: got valid=%b level=%0d, want 0 0", out_valid, fifo_level);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      out_ready = 1'b0;
      push_word(16'h2211);
      tick();
      tick();
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== 8'h11) begin
            n_fail++;
            $display("FAIL bp_hold_%0d: got valid=%b data=%h, want 1 11", i, out_valid, out_data);
         end
         tick();
      end
      out_ready = 1'b1;
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h22) begin
         n_fail++;
         $display("FAIL bp_release_byte1: got valid=%b data=%h, want 1 22", out_valid, out_data);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_no_duplicate: got valid=%b, want 0", out_valid);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_overflow();
      logic [7:0] exp_bytes [10];
      exp_bytes = '{8'h50, 8'h5A, 8'h01, 8'h11, 8'h02, 8'h12, 8'h03, 8'h13, 8'h04, 8'h14};
      do_reset();
      out_ready = 1'b0;
      push_word(16'h5A50);
      tick();
      tick();
      for (int i = 1; i <= 6; i++) push_word({8'(16 + i), 8'(i)});
      n_checks++;
      if (fifo_level !== 3'd4 || overflow !== 1'b1 || drop_cnt !== 8'd2) begin
         n_fail++;
         $display("FAIL ovf_after_six: got level=%0d ovf=%b drops=%0d, want 4 1 2", fifo_level, overflow, drop_cnt);
      end
      pix_data  = 16'hFFFF;
      pix_valid = 1'b1;
      for (int i = 0; i < 260; i++) tick();
      pix_valid = 1'b0;
      n_checks++;
      if (drop_cnt !== 8'd255 || fifo_level !== 3'd4) begin
         n_fail++;
         $display("FAIL ovf_saturate: got drops=%0d level=%0d, want 255 4", drop_cnt, fifo_level);
      end
      clear_ovf = 1'b1;
      tick();
      clear_ovf = 1'b0;
      n_checks++;
      if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL ovf_clear: got ovf=%b drops=%0d, want 0 0", overflow, drop_cnt);
      end
      clear_ovf = 1'b1;
      pix_valid = 1'b1;
      tick();
      clear_ovf = 1'b0;
      pix_valid = 1'b0;
      n_checks++;
      if (overflow !== 1'b1 || drop_cnt !== 8'd1) begin
         n_fail++;
         $display("FAIL ovf_clear_with_drop: got ovf=%b drops=%0d, want 1 1", overflow, drop_cnt);
      end
      clear_ovf = 1'b1;
      tick();
      clear_ovf = 1'b0;
      out_ready = 1'b1;
      collect(40);
      out_ready = 1'b0;
      n_checks++;
      if (got_data.size() != 10) begin
         n_fail++;
         $display("FAIL ovf_drain_count: got %0d bytes, want 10", got_data.size());
      end
      for (int i = 0; i < 10 && i < got_data.size(); i++) begin
         n_checks++;
         if (got_data[i] !== exp_bytes[i]) begin
            n_fail++;
            $display("FAIL ovf_drain_byte%0d: got %h want %h", i, got_data[i], exp_bytes[i]);
         end
      end
   endtask

   task automatic test_frame_wrap();
      do_reset();
      out_ready = 1'b0;
      push_word(16'h0201);
      push_word(16'h0403);
      push_word(16'h0605);
      push_word(16'h0807);
      out_ready = 1'b1;
      collect(30);
      out_ready = 1'b0;
      n_checks++;
      if (got_data.size() != 8) begin
         n_fail++;
         $display("FAIL frame_count: got %0d bytes, want 8", got_data.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (got_data[i] !== 8'(i + 1) || got_sof[i] !== (i == 0 || i == 4) || got_eof[i] !== (i == 3 || i == 7)) begin
               n_fail++;
               $display("FAIL frame_byte%0d: got data=%h sof=%b eof=%b, want %h %b %b", i, got_data[i],
                        got_sof[i], got_eof[i], 8'(i + 1), (i == 0 || i == 4), (i == 3 || i == 7));
            end
         end
         n_checks++;
         if (got_cyc[7] - got_cyc[0] != 10) begin
            n_fail++;
            $display("FAIL frame_back_to_back: got span %0d cycles, want 10", got_cyc[7] - got_cyc[0]);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      do_reset();
      out_ready = 1'b1;
      push_word(16'h0A09);
      collect(6);
      out_ready = 1'b0;
      push_word(16'h2221);
      push_word(16'h2423);
      push_word(16'h2625);
      push_word(16'h2827);
      n_checks++;
      if (out_valid !== 1'b1 || fifo_level !== 3'd3 || out_sof !== 1'b0 || out_data !== 8'h21) begin
         n_fail++;
         $display("FAIL midreset_setup: got valid=%b level=%0d sof=%b data=%h, want 1 3 0 21",
                  out_valid, fifo_level, out_sof, out_data);
      end
      reset = 1'b0;
      #2;
      n_checks++;
      if ({out_valid, out_data, out_sof, out_eof, overflow, drop_cnt, fifo_level} !== 21'd0) begin
         n_fail++;
         $display("FAIL midreset_outputs: got valid=%b data=%h sof=%b eof=%b ovf=%b drops=%0d level=%0d, want all 0",
                  out_valid, out_data, out_sof, out_eof, overflow, drop_cnt, fifo_level);
      end
      @(negedge clk);
      reset = 1'b1;
      tick();
      out_ready = 1'b1;
      push_word(16'h0C0B);
      tick();
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h0B || out_sof !== 1'b1) begin
         n_fail++;
         $display("FAIL midreset_new_sof: got valid=%b data=%h sof=%b, want 1 0b 1", out_valid, out_data, out_sof);
      end
      tick();
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin
         n_fail++;
         $display("FAIL midreset_discarded: got valid=%b level=%0d, want 0 0", out_valid, fifo_level);
      end
      out_ready = 1'b0;
   endtask

`ifdef PIXEL_RO_CHECKSUM_EN
   task automatic test_checksum();
      logic [7:0] exp_bytes [5];
      exp_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
      do_reset();
      out_ready = 1'b0;
      push_word(16'h0201);
      push_word(16'h0403);
      out_ready = 1'b1;
      collect(20);
      out_ready = 1'b0;
      n_checks++;
      if (got_data.size() != 5) begin
         n_fail++;
         $display("FAIL cksum_count: got %0d bytes, want 5", got_data.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (got_data[i] !== exp_bytes[i] || got_eof[i] !== (i == 4) || got_sof[i] !== (i == 0)) begin
               n_fail++;
               $display("FAIL cksum_byte%0d: got data=%h sof=%b eof=%b, want %h %b %b", i, got_data[i],
                        got_sof[i], got_eof[i], exp_bytes[i], (i == 0), (i == 4));
            end
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_word();
      test_backpressure();
      test_reset_mid_frame();
`ifdef PIXEL_RO_CHECKSUM_EN
      test_checksum();
`else
      test_overflow();
      test_frame_wrap();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, want completion");
      $fatal(1, "timeout");
   end

endmodule
